lcd_hd44780_responder: RTL and testbench

- Behavioural, synthesizable responder for the HD44780-style character LCD bus driven by the team's LCD initiator/controller pair.
- Samples LCD_EN/LCD_RS/LCD_RW/LCD_DATA, decodes commands and data writes, and keeps a 2x16 character buffer, address counter and display-control state.
- Exposes a read port and sticky protocol-error flags so benches and on-board self-checks can confirm what the initiator wrote (e.g. weekday strings).

---
 rtl/lcd_hd44780_responder.sv | 182 ++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780-style LCD bus responder: turns initiator strobes into a 2x16 character buffer plus control state.
// Optional macro LCD_RESP_INIT_CHECK_EN demands an 8-bit Function Set before data or DDRAM access.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES = 40,
  parameter int CLR_CYCLES  = 1600,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [7:0]  LCD_DATA,
  input  logic        LCD_RW,
  input  logic        LCD_EN,
  input  logic        LCD_RS,
  input  logic [4:0]  iRD_ADDR,
  output logic [7:0]  oRD_DATA,
  output logic [4:0]  oAC,
  output logic        oDISP_ON,
  output logic        oCURSOR_ON,
  output logic        oBLINK_ON,
  output logic [1:0]  oFUNC,
  output logic        oBUSY,
  output logic [15:0] oWR_CNT,
  input  logic        iERR_CLR,
  output logic [3:0]  oERR
);
  localparam int BMAX = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int WW   = $clog2(MIN_EN_HIGH + 1);

  typedef enum logic {ST_IDLE, ST_FILL} state_t;
  state_t state, state_nxt;

  logic          en_s1, en_s2, en_s3, rs_s1, rs_s2, rw_s1, rw_s2;
  logic [7:0]    dat_s1, dat_s2;
  logic [WW-1:0] width;
  logic [BW-1:0] busy_cnt;
  logic [4:0]    fill_idx;
  logic [7:0]    mem [32];
  logic          id;

  logic          fall, accept, wr_en, start_clr, id_nxt, init_ok;
  logic [3:0]    err_set;
  logic [4:0]    ac_nxt;
  logic [1:0]    func_nxt;
  logic [2:0]    dcb_nxt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      {en_s1, en_s2, en_s3, rs_s1, rs_s2, rw_s1, rw_s2} <= '0;
      dat_s1 <= '0;
      dat_s2 <= '0;
      width  <= '0;
    end else begin
      {en_s1, rs_s1, rw_s1, dat_s1} <= {LCD_EN, LCD_RS, LCD_RW, LCD_DATA};
      {en_s2, rs_s2, rw_s2, dat_s2} <= {en_s1, rs_s1, rw_s1, dat_s1};
      en_s3 <= en_s2;
      if (!en_s2)
        width <= '0;
      else if (width != WW'(MIN_EN_HIGH))
        width <= width + WW'(1);
    end
  end

  // width still holds the completed high time during the falling-edge cycle
  assign fall  = en_s3 & ~en_s2;
  assign oBUSY = (busy_cnt != '0);

`ifdef LCD_RESP_INIT_CHECK_EN
  logic init_done;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      init_done <= 1'b0;
    else if (accept && !rs_s2 && dat_s2[7:5] == 3'b001 && dat_s2[4])
      init_done <= 1'b1;
  end
  assign init_ok = init_done;
`else
  assign init_ok = 1'b1;
`endif

  always_comb begin
    err_set   = 4'h0;
    accept    = 1'b0;
    wr_en     = 1'b0;
    start_clr = 1'b0;
    ac_nxt    = oAC;
    id_nxt    = id;
    func_nxt  = oFUNC;
    dcb_nxt   = {oDISP_ON, oCURSOR_ON, oBLINK_ON};
    if (fall) begin
      if (width < WW'(MIN_EN_HIGH)) err_set[1] = 1'b1;
      else if (rw_s2)               err_set[2] = 1'b1;
      else if (oBUSY)               err_set[0] = 1'b1;
      else                          accept     = 1'b1;
    end
    if (accept) begin
      if (rs_s2) begin
        if (!init_ok) err_set[3] = 1'b1;
        else begin
          wr_en  = 1'b1;
          ac_nxt = id ? oAC + 5'd1 : oAC - 5'd1;
        end
      end else if (dat_s2[7]) begin
        if (!init_ok)                     err_set[3] = 1'b1;
        else if (dat_s2[6:4] == 3'b000)   ac_nxt = {1'b0, dat_s2[3:0]};
        else if (dat_s2[6:4] == 3'b100)   ac_nxt = {1'b1, dat_s2[3:0]};
        else                              err_set[3] = 1'b1;
      end else if (dat_s2[6]) begin
        err_set[3] = 1'b1;
      end else if (dat_s2[5]) begin
        func_nxt = dat_s2[4:3];
`ifdef LCD_RESP_INIT_CHECK_EN
        if (!dat_s2[4]) err_set[3] = 1'b1;
`endif
      end else if (dat_s2[4]) begin
        if (dat_s2[3]) err_set[3] = 1'b1;
        else           ac_nxt = dat_s2[2] ? oAC + 5'd1 : oAC - 5'd1;
      end else if (dat_s2[3]) begin
        dcb_nxt = dat_s2[2:0];
      end else if (dat_s2[2]) begin
        id_nxt = dat_s2[1];
        if (dat_s2[0]) err_set[3] = 1'b1;
      end else if (dat_s2[1]) begin
        ac_nxt = 5'd0;
      end else if (dat_s2[0]) begin
        start_clr = 1'b1;
        ac_nxt    = 5'd0;
        id_nxt    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_clr) state_nxt = ST_FILL;
      ST_FILL: if (fill_idx == 5'd31) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_IDLE;
      fill_idx   <= 5'd0;
      busy_cnt   <= '0;
      oAC        <= 5'd0;
      id         <= 1'b1;
      oDISP_ON   <= 1'b0;
      oCURSOR_ON <= 1'b0;
      oBLINK_ON  <= 1'b0;
      oFUNC      <= 2'b00;
      oWR_CNT    <= 16'd0;
      oERR       <= 4'h0;
    end else begin
      state    <= state_nxt;
      fill_idx <= (state == ST_FILL) ? fill_idx + 5'd1 : 5'd0;
      if (accept)
        busy_cnt <= start_clr ? BW'(CLR_CYCLES) : BW'(BUSY_CYCLES);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - BW'(1);
      oAC   <= ac_nxt;
      id    <= id_nxt;
      {oDISP_ON, oCURSOR_ON, oBLINK_ON} <= dcb_nxt;
      oFUNC <= func_nxt;
      if (wr_en && oWR_CNT != 16'hFFFF)
        oWR_CNT <= oWR_CNT + 16'd1;
      oERR <= (iERR_CLR ? 4'h0 : oERR) | err_set;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
      oRD_DATA <= 8'h20;
    end else begin
      if (state == ST_FILL) mem[fill_idx] <= 8'h20;
      else if (wr_en)       mem[oAC]      <= dat_s2;
      oRD_DATA <= mem[iRD_ADDR];
    end
  end
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed + randomized bench for lcd_hd44780_responder against a behavioural LCD model.
module tb_lcd_hd44780_responder;
  localparam int BUSY_CYCLES = 40;
  localparam int CLR_CYCLES  = 1600;
  localparam int MIN_EN_HIGH = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [7:0]  LCD_DATA = 8'h00;
  logic        LCD_RW = 1'b0, LCD_EN = 1'b0, LCD_RS = 1'b0;
  logic [4:0]  iRD_ADDR = 5'd0;
  logic        iERR_CLR = 1'b0;
  logic [7:0]  oRD_DATA;
  logic [4:0]  oAC;
  logic        oDISP_ON, oCURSOR_ON, oBLINK_ON, oBUSY;
  logic [1:0]  oFUNC;
  logic [15:0] oWR_CNT;
  logic [3:0]  oERR;

  lcd_hd44780_responder #(
    .BUSY_CYCLES(BUSY_CYCLES), .CLR_CYCLES(CLR_CYCLES), .MIN_EN_HIGH(MIN_EN_HIGH)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .LCD_DATA(LCD_DATA), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_RS(LCD_RS), .iRD_ADDR(iRD_ADDR), .oRD_DATA(oRD_DATA), .oAC(oAC), .oDISP_ON(oDISP_ON),
    .oCURSOR_ON(oCURSOR_ON), .oBLINK_ON(oBLINK_ON), .oFUNC(oFUNC), .oBUSY(oBUSY),
    .oWR_CNT(oWR_CNT), .iERR_CLR(iERR_CLR), .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0, failures = 0;
  int k, busy_n, sel;
  logic [7:0] m_buf [32];
  int         m_ac, m_wr;
  bit         m_id;
  logic [1:0] m_func;
  logic [2:0] m_dcb;
  logic [3:0] m_err;
  logic [7:0] seg [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    m_ac = 0; m_id = 1'b1; m_func = 2'b00; m_dcb = 3'b000; m_wr = 0; m_err = 4'h0;
  endtask

  // Behaviour of an accepted transfer, decoded by opcode range.
  task automatic model_apply(input bit rs, input logic [7:0] d);
    int a;
    if (rs) begin
      m_buf[m_ac] = d;
      if (m_wr < 65535) m_wr++;
      m_ac = m_id ? (m_ac + 1) % 32 : (m_ac + 31) % 32;
    end else if (d >= 8'h80) begin
      a = int'(d) - 128;
      if (a < 16) m_ac = a;
      else if (a >= 64 && a < 80) m_ac = 16 + (a - 64);
      else m_err[3] = 1'b1;
    end else if (d >= 8'h40) m_err[3] = 1'b1;
    else if (d >= 8'h20) m_func = d[4:3];
    else if (d >= 8'h10) begin
      if (d[3]) m_err[3] = 1'b1;
      else m_ac = d[2] ? (m_ac + 1) % 32 : (m_ac + 31) % 32;
    end else if (d >= 8'h08) m_dcb = d[2:0];
    else if (d >= 8'h04) begin
      m_id = d[1];
      if (d[0]) m_err[3] = 1'b1;
    end else if (d >= 8'h02) m_ac = 0;
    else if (d == 8'h01) begin
      m_ac = 0; m_id = 1'b1;
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
    end
  endtask

  task automatic pulse(input bit rs, input bit rw, input logic [7:0] d, input int hi);
    @(negedge iCLK); LCD_RS = rs; LCD_RW = rw; LCD_DATA = d;
    @(negedge iCLK); LCD_EN = 1'b1;
    repeat (hi) @(negedge iCLK);
    LCD_EN = 1'b0;
    repeat (4) @(negedge iCLK);
  endtask

  task automatic wait_idle();
    k = 0;
    while (oBUSY === 1'b1 && k < 5000) begin @(negedge iCLK); k++; end
    check("busy_timeout", oBUSY, 1'b0);
  endtask

  task automatic send(input bit rs, input logic [7:0] d);
    pulse(rs, 1'b0, d, MIN_EN_HIGH);
    model_apply(rs, d);
    wait_idle();
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge iCLK); iRD_ADDR = 5'(i);
      @(negedge iCLK); check(tag, oRD_DATA, m_buf[i]);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ac"}, oAC, m_ac);
    check({tag, "_wr"}, oWR_CNT, m_wr);
    check({tag, "_err"}, oERR, m_err);
    check({tag, "_func"}, oFUNC, m_func);
    check({tag, "_dcb"}, {oDISP_ON, oCURSOR_ON, oBLINK_ON}, m_dcb);
  endtask

  task automatic clear_errs();
    @(negedge iCLK); iERR_CLR = 1'b1;
    @(negedge iCLK); iERR_CLR = 1'b0;
    m_err = 4'h0;
    check("err_clr", oERR, 4'h0);
  endtask

  initial begin
    seg = '{8'h53, 8'h65, 8'h67, 8'h75, 8'h6E, 8'h64, 8'h61, 8'h20};
    model_reset();
    repeat (3) @(negedge iCLK);
    check_state("in_reset");
    check("in_reset_busy", oBUSY, 1'b0);
    check("in_reset_rd", oRD_DATA, 8'h20);
    iRST_N = 1'b1;
    check_buf("reset_buf");

    send(0, 8'h38); send(0, 8'h0C); send(0, 8'h01); send(0, 8'h06); send(0, 8'h80);
    for (int i = 0; i < 8; i++) send(1, seg[i]);
    check_buf("segunda_buf");
    check_state("segunda");
    check("segunda_ac8", oAC, 5'd8);
    check("segunda_disp", {oDISP_ON, oCURSOR_ON}, 2'b10);

    send(0, 8'hC0);
    for (int i = 0; i < 17; i++) send(1, 8'($urandom_range(33, 126)));
    check_buf("line2_wrap_buf");
    check_state("line2_wrap");

    pulse(1, 0, 8'h41, MIN_EN_HIGH);
    model_apply(1, 8'h41);
    pulse(1, 0, 8'h42, MIN_EN_HIGH);
    m_err[0] = 1'b1;
    check("busy_strobe_busy", oBUSY, 1'b1);
    wait_idle();
    check_state("busy_strobe");
    check_buf("busy_strobe_buf");
    clear_errs();

    pulse(1, 0, 8'h5A, 2);
    m_err[1] = 1'b1;
    check("short_en_busy", oBUSY, 1'b0);
    check_state("short_en");
    check_buf("short_en_buf");
    clear_errs();

    pulse(1, 1, 8'h5A, MIN_EN_HIGH);
    m_err[2] = 1'b1;
    check("rw_busy", oBUSY, 1'b0);
    check_state("rw_strobe");
    clear_errs();

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       send(1, 8'($urandom_range(33, 126)));
      else if (sel == 5) send(0, 8'h80 | 8'($urandom_range(0, 15)));
      else if (sel == 6) send(0, 8'hC0 | 8'($urandom_range(0, 15)));
      else if (sel == 7) send(0, 8'h10 | (8'($urandom_range(0, 1)) << 2));
      else if (sel == 8) send(0, 8'h04 | (8'($urandom_range(0, 1)) << 1));
      else               send(0, 8'h80 | 8'($urandom_range(16, 63)));
    end
    check_state("random");
    check_buf("random_buf");
    clear_errs();

    send(0, 8'h06); send(0, 8'h80);
    for (int i = 0; i < 32; i++) send(1, 8'($urandom_range(33, 126)));
    check_buf("full_buf");
    @(negedge iCLK); LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DATA = 8'h01;
    @(negedge iCLK); LCD_EN = 1'b1;
    repeat (MIN_EN_HIGH) @(negedge iCLK);
    LCD_EN = 1'b0;
    model_apply(0, 8'h01);
    busy_n = 0; k = 0;
    while (k < CLR_CYCLES + 100 && !(busy_n > 0 && oBUSY === 1'b0)) begin
      @(negedge iCLK);
      if (oBUSY === 1'b1) busy_n++;
      k++;
    end
    check("clr_busy_len", busy_n, CLR_CYCLES);
    check_state("clear");
    check_buf("clear_buf");

    send(0, 8'hC4);
    for (int i = 0; i < 12; i++) send(1, 8'($urandom_range(33, 126)));
    @(negedge iCLK); LCD_DATA = 8'h01;
    @(negedge iCLK); LCD_EN = 1'b1;
    repeat (MIN_EN_HIGH) @(negedge iCLK);
    LCD_EN = 1'b0;
    k = 0;
    while (oBUSY !== 1'b1 && k < 20) begin @(negedge iCLK); k++; end
    check("clr2_busy_rise", oBUSY, 1'b1);
    repeat (10) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    model_reset();
    check_state("mid_clr_rst");
    check("mid_clr_rst_busy", oBUSY, 1'b0);
    check("mid_clr_rst_rd", oRD_DATA, 8'h20);
    @(negedge iCLK); iRST_N = 1'b1;
    check_buf("mid_clr_rst_buf");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
